// File: rtl/cascade_counter.sv
// cascade_counter: NUM_STAGES cascaded modulo-STAGE_MOD digit counters.
// Carries are combinational lookahead, so every digit that must move does so
// on the same clock edge.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset (clears digits and ovf)
//   enable     advance request for stage 0
//   up_dn      direction, 1 = up, 0 = down (used in the same cycle)
//   load       synchronous parallel load, overrides enable
//   load_value load digits, stage i at [(i+1)*STAGE_WIDTH-1 : i*STAGE_WIDTH];
//              fields >= STAGE_MOD load as 0
//   ovf_clr    clear for ovf (a simultaneous full-chain wrap wins)
//   count      registered digits, same packing as load_value
//   stage_tc   per-stage terminal count: stage i wraps on the next edge
//   TCout      chain terminal count, stage_tc[NUM_STAGES-1]
//   ovf        sticky full-chain overflow/underflow flag

// One digit: modulo-MOD up/down counter with clamped parallel load.
module cascade_stage #(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         adv,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] digit,
  output logic         at_term
);
  localparam logic [W-1:0] MAXV = W'(MOD - 1);
  // One extra bit so MOD == 2**W is representable.
  localparam logic [W:0]   MODV = (W + 1)'(MOD);

  logic load_ok;

  assign load_ok = ({1'b0, load_val} < MODV);
  assign at_term = up_dn ? (digit == MAXV) : (digit == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      digit <= '0;
    else if (load)
      digit <= load_ok ? load_val : '0;
    else if (adv) begin
      if (up_dn) digit <= at_term ? '0   : digit + 1'b1;
      else       digit <= at_term ? MAXV : digit - 1'b1;
    end
  end
endmodule

module cascade_counter #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_WIDTH = 4,
  parameter int STAGE_MOD   = 10
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              up_dn,
  input  logic                              load,
  input  logic [NUM_STAGES*STAGE_WIDTH-1:0] load_value,
  input  logic                              ovf_clr,
  output logic [NUM_STAGES*STAGE_WIDTH-1:0] count,
  output logic [NUM_STAGES-1:0]             stage_tc,
  output logic                              TCout,
  output logic                              ovf
);
  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] digits;
  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] ld_digits;
  logic [NUM_STAGES-1:0]                  adv;
  logic [NUM_STAGES-1:0]                  at_term;

  assign ld_digits = load_value;
  assign count     = digits;

  // Lookahead carry: a stage advances when every lower stage is at terminal.
  assign adv[0] = enable;
  genvar i;
  generate
    for (i = 1; i < NUM_STAGES; i++) begin : g_adv
      assign adv[i] = adv[i-1] & at_term[i-1];
    end

    for (i = 0; i < NUM_STAGES; i++) begin : g_stage
      cascade_stage #(.W(STAGE_WIDTH), .MOD(STAGE_MOD)) u_stage (
        .clock    (clock),
        .reset    (reset),
        .adv      (adv[i]),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (ld_digits[i]),
        .digit    (digits[i]),
        .at_term  (at_term[i])
      );
    end
  endgenerate

  // No wrap can happen during load or reset, so terminal count is masked.
  assign stage_tc = adv & at_term & {NUM_STAGES{~load & reset}};
  assign TCout    = stage_tc[NUM_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       ovf <= 1'b0;
    else if (TCout)   ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
endmodule

// File: doc/cascade_counter.md
CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 SHALL provide parameter NUM_STAGES, default 4: number of cascaded counter stages (digits), legal range 1..64.
REQ-002 SHALL provide parameter STAGE_WIDTH, default 4: bits per stage, legal range 1..16.
REQ-003 SHALL provide parameter STAGE_MOD, default 10: modulus of every stage, legal range 2..2**STAGE_WIDTH.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port `clock`, input, 1 bit: rising-edge clock for all state.
REQ-006 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port `enable`, input, 1 bit: count-advance request for stage 0.
REQ-008 SHALL have port `up_dn`, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-009 SHALL have port `load`, input, 1 bit: synchronous parallel load.
REQ-010 SHALL have port `load_value`, input, NUM_STAGES*STAGE_WIDTH bits: value for parallel load, with stage i in bits [(i+1)*STAGE_WIDTH-1 : i*STAGE_WIDTH].
REQ-011 SHALL have port `ovf_clr`, input, 1 bit: clear for the sticky overflow flag.
REQ-012 SHALL have port `count`, output, NUM_STAGES*STAGE_WIDTH bits: registered digits, using the same packing as load_value.
REQ-013 SHALL have port `stage_tc`, output, NUM_STAGES bits: per-stage terminal count, combinational.
REQ-014 SHALL have port `TCout`, output, 1 bit: chain terminal count, equal to stage_tc[NUM_STAGES-1].
REQ-015 SHALL have port `ovf`, output, 1 bit: sticky overflow/underflow flag, registered.

Function
REQ-016 SHALL define the terminal digit value as STAGE_MOD-1 when up_dn=1 and 0 when up_dn=0; up_dn is sampled in the same cycle it is used and has no pipeline delay.
REQ-017 SHALL define the advance condition adv[0] = enable, and adv[i] = adv[i-1] AND (digit i-1 == terminal) for i > 0.
REQ-018 SHALL compute adv as combinational lookahead, so all stages update on the same clock edge, with no registered ripple between stages.
REQ-019 SHALL, for a stage with adv[i]=1 and load=0 when counting up, step digit d to d+1, wrapping STAGE_MOD-1 to 0.
REQ-020 SHALL, for a stage with adv[i]=1 and load=0 when counting down, step digit d to d-1, wrapping 0 to STAGE_MOD-1.
REQ-021 SHALL hold a stage's digit unchanged when adv[i]=0 and load=0.
REQ-022 SHALL drive stage_tc[i] = adv[i] AND (digit i == terminal), meaning stage i wraps on the next edge.
REQ-023 SHALL give load priority over enable: with load=1, every digit takes its load_value field on the next edge.
REQ-024 SHALL load 0 into any load_value field whose value is >= STAGE_MOD.
REQ-025 SHALL force stage_tc, and therefore TCout, to 0 during any cycle with load=1.
REQ-026 SHALL set ovf on any edge where TCout=1 (full-chain wrap, either direction).
REQ-027 SHALL clear ovf on an edge where ovf_clr=1 and TCout=0; when ovf_clr and TCout are both 1 on the same edge, set wins.
REQ-028 SHALL keep the count latency at one edge from enable/load to the updated count, with no other pipeline delay.
REQ-029 SHALL, when NUM_STAGES=1, behave as a single modulo-STAGE_MOD counter with TCout = stage_tc[0].

Reset
REQ-030 SHALL, on reset=0, asynchronously (without a clock edge) clear all digits to 0 and clear ovf to 0.
REQ-031 SHALL force stage_tc and TCout to 0 while reset=0, regardless of enable or up_dn.
REQ-032 SHALL, on the first edge after reset deasserts, respond normally to enable, load and up_dn with no extra idle cycle.

Verification
REQ-033 SHALL cover, with default parameters, full count-up from reset: enable=1 and up_dn=1 for 9999 edges -> count=16'h9999 and TCout=1; on the next edge -> count=16'h0000 and ovf=1.
REQ-034 SHALL cover lookahead carry: load 16'h0199, then one enabled up cycle -> stage_tc=4'b0011 in that cycle, then count=16'h0200 and ovf=0.
REQ-035 SHALL cover down-count underflow: from reset, up_dn=0 and enable=1 for one cycle -> TCout=1 in that cycle, then count=16'h9999 and ovf=1.
REQ-036 SHALL cover load priority and clamping: load=1, enable=1, load_value=16'h00A5 -> count=16'h0005 and TCout=0 in the load cycle.
REQ-037 SHALL cover the ovf clear race: ovf=1, count=16'h9999 counting up, ovf_clr=1 with enable=1 -> ovf stays 1; a later ovf_clr=1 with TCout=0 -> ovf=0.
REQ-038 SHALL cover mid-count reset: count=16'h4321, reset driven low between clock edges -> count=0, ovf=0 and TCout=0 immediately, with no clock edge.
